breakpoint_ctrl: RTL

//   Hardware breakpoint scheduler for instrumented debug designs.
//   - Arbitrates (instance_id, stmt_id) trace events from NUM_SRC instrumented instances.
//   - Matches each accepted event against a programmable breakpoint table.
//   - On a hit, halts the design and holds until the debugger asserts resume.

---
 rtl/breakpoint_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/breakpoint_ctrl.sv
// breakpoint_ctrl: hardware breakpoint scheduler.
// Picks trace events from NUM_SRC sources in round-robin order and compares
// each one against a programmable breakpoint table. On a hit the design
// halts until the debugger asserts resume.
// Optional feature macro: BP_STEP_EN adds a step_mode input. While it is
// high, every checked event counts as a hit.
module breakpoint_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 32,
    parameter int STMT_W  = 32,
    parameter int NUM_BP  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*ID_W-1:0]       src_instance_id,
    input  logic [NUM_SRC*STMT_W-1:0]     src_stmt_id,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_BP)-1:0]     cfg_idx,
    input  logic                          cfg_en,
    input  logic [ID_W-1:0]               cfg_instance_id,
    input  logic [STMT_W-1:0]             cfg_stmt_id,
    input  logic                          resume,
`ifdef BP_STEP_EN
    input  logic                          step_mode,
`endif
    output logic                          halt,
    output logic [$clog2(NUM_SRC)-1:0]    hit_src,
    output logic [ID_W-1:0]               hit_instance_id,
    output logic [STMT_W-1:0]             hit_stmt_id,
    output logic [15:0]                   hit_count
);

    localparam int SRC_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;

    // Breakpoint table
    logic              bp_en   [NUM_BP];
    logic [ID_W-1:0]   bp_inst [NUM_BP];
    logic [STMT_W-1:0] bp_stmt [NUM_BP];

    // Round-robin start index and the latched event
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  lat_src;
    logic [ID_W-1:0]   lat_inst;
    logic [STMT_W-1:0] lat_stmt;

    logic [SRC_W-1:0]  cand;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_any;
    logic              bp_match;
    logic              hit_now;

    // Round-robin grant search starting at rr_ptr; only offered in IDLE
    always_comb begin
        src_ready = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (state == IDLE) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                cand = SRC_W'((32'(rr_ptr) + k) % NUM_SRC);
                if (!grant_any && src_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_any) begin
                src_ready[grant_idx] = 1'b1;
            end
        end
    end

    // Parallel compare of the latched event against all enabled entries
    always_comb begin
        bp_match = 1'b0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (bp_inst[i] == lat_inst) && (bp_stmt[i] == lat_stmt)) begin
                bp_match = 1'b1;
            end
        end
`ifdef BP_STEP_EN
        hit_now = bp_match || step_mode;
`else
        hit_now = bp_match;
`endif
    end

    // Table writes, FSM sequencing and registered hit outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            lat_src         <= '0;
            lat_inst        <= '0;
            lat_stmt        <= '0;
            halt            <= 1'b0;
            hit_src         <= '0;
            hit_instance_id <= '0;
            hit_stmt_id     <= '0;
            hit_count       <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                bp_en[i]   <= 1'b0;
                bp_inst[i] <= '0;
                bp_stmt[i] <= '0;
            end
        end else begin
            // The compare in CHECK reads the pre-write entry because the
            // write lands at this same edge.
            if (cfg_we) begin
                bp_en[cfg_idx]   <= cfg_en;
                bp_inst[cfg_idx] <= cfg_instance_id;
                bp_stmt[cfg_idx] <= cfg_stmt_id;
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        lat_src  <= grant_idx;
                        lat_inst <= src_instance_id[grant_idx*ID_W +: ID_W];
                        lat_stmt <= src_stmt_id[grant_idx*STMT_W +: STMT_W];
                        rr_ptr   <= SRC_W'((32'(grant_idx) + 1) % NUM_SRC);
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit_now) begin
                        hit_src         <= lat_src;
                        hit_instance_id <= lat_inst;
                        hit_stmt_id     <= lat_stmt;
                        if (hit_count != 16'hFFFF) begin
                            hit_count <= hit_count + 16'd1;
                        end
                        halt  <= 1'b1;
                        state <= HALT;
                    end else begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    if (resume) begin
                        halt  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    halt  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
